// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
// Holds the scan FSM states, the key code table and the default timing constants.
package keypad_pkg;

  typedef enum logic {
    SCAN,
    EVAL
  } scanState_t;

  localparam int DEFAULT_SCAN_DIV       = 1000;
  localparam int DEFAULT_DEBOUNCE_SCANS = 4;

  // Indexed [row][column]; row 3 wraps the 0 key into the first column.
  localparam logic [3:0] KEY_CODES [4][4] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'h0, 4'hF, 4'hE, 4'hD}
  };

  function automatic logic [3:0] keyCode(input logic [1:0] row, input logic [1:0] col);
    return KEY_CODES[row][col];
  endfunction

endpackage

// File: rtl/keypad_if.sv
// Keypad matrix lines plus the debounced key report towards the decoder.
// The scanner is the master; the matrix/decoder side is the slave.
interface keypad_if;

  logic [3:0] col_n;
  logic [3:0] row_n;
  logic [3:0] keyValue;
  logic       keyPressed;
  logic       keyEvent;

  modport master (
    output col_n,
    output keyValue,
    output keyPressed,
    output keyEvent,
    input  row_n
  );

  modport slave (
    input  col_n,
    input  keyValue,
    input  keyPressed,
    input  keyEvent,
    output row_n
  );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for the asynchronous, active-low row lines.
// Resets to all-ones so an idle (pulled-up) matrix is seen during and after reset.
module sync_2ff (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] d,
  output logic [3:0] q
);

  logic [3:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 4'b1111;
      q    <= 4'b1111;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: drives one column at a time, samples the rows,
// and debounces whole-sweep results into a stable key report.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = DEFAULT_SCAN_DIV,
  parameter int DEBOUNCE_SCANS = DEFAULT_DEBOUNCE_SCANS
) (
  input  logic     clk,
  input  logic     rst_n,
  keypad_if.master keys
);

  localparam logic [15:0] DIV_LAST   = 16'(SCAN_DIV - 1);
  localparam logic [3:0]  DEB_TARGET = 4'(DEBOUNCE_SCANS);

  scanState_t state, nextState;
  logic        running;
  logic [1:0]  col, nextCol;
  logic [15:0] divCnt, nextDiv;
  logic        sampleNow;
  logic        evalNow;
  logic [3:0]  colDrive, colReg;

  logic [3:0]  syncRow;
  logic        rowHit;
  logic [1:0]  firstRow;

  logic        hitFound;
  logic [3:0]  hitCode;
  logic [3:0]  prevCode;
  logic [3:0]  matchCnt, matchNext;
  logic [3:0]  releaseCnt, releaseNext;
  logic [3:0]  keyValueReg;
  logic        keyPressedReg;
  logic        keyEventReg;

  function automatic logic [3:0] satInc(input logic [3:0] v);
    return (v >= DEB_TARGET) ? DEB_TARGET : v + 4'd1;
  endfunction

  sync_2ff rowSync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (keys.row_n),
    .q    (syncRow)
  );

  // Lowest active row wins within a column.
  always_comb begin
    rowHit   = (syncRow != 4'b1111);
    firstRow = 2'd0;
    for (int r = 3; r >= 0; r--) begin
      if (!syncRow[r]) firstRow = 2'(r);
    end
  end

  // The first clock after reset only starts the scan, so column 0 gets its full SCAN_DIV cycles.
  always_comb begin
    nextState = state;
    nextCol   = col;
    nextDiv   = divCnt;
    sampleNow = 1'b0;
    if (running) begin
      case (state)
        SCAN: begin
          if (divCnt == DIV_LAST) begin
            sampleNow = 1'b1;
            nextDiv   = 16'd0;
            if (col == 2'd3) nextState = EVAL;
            else             nextCol   = col + 2'd1;
          end else begin
            nextDiv = divCnt + 16'd1;
          end
        end
        EVAL: begin
          nextState = SCAN;
          nextCol   = 2'd0;
        end
      endcase
    end
    colDrive = (nextState == EVAL) ? 4'b1111 : (4'b1111 ^ (4'b0001 << nextCol));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= SCAN;
      col     <= 2'd0;
      divCnt  <= 16'd0;
      running <= 1'b0;
      colReg  <= 4'b1111;
    end else begin
      state   <= nextState;
      col     <= nextCol;
      divCnt  <= nextDiv;
      running <= 1'b1;
      colReg  <= colDrive;
    end
  end

  assign evalNow = running && (state == EVAL);

  always_comb begin
    matchNext = 4'd0;
    if (hitFound) begin
      matchNext = (matchCnt != 4'd0 && hitCode == prevCode) ? satInc(matchCnt) : 4'd1;
    end
    releaseNext = hitFound ? 4'd0 : satInc(releaseCnt);
  end

  // Press debounce runs only while released and release debounce only while pressed,
  // so the reported key is frozen for the whole duration of a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hitFound      <= 1'b0;
      hitCode       <= 4'd0;
      prevCode      <= 4'd0;
      matchCnt      <= 4'd0;
      releaseCnt    <= 4'd0;
      keyValueReg   <= 4'd0;
      keyPressedReg <= 1'b0;
      keyEventReg   <= 1'b0;
    end else begin
      keyEventReg <= 1'b0;
      if (sampleNow && !hitFound && rowHit) begin
        hitFound <= 1'b1;
        hitCode  <= keyCode(firstRow, col);
      end
      if (evalNow) begin
        hitFound <= 1'b0;
        prevCode <= hitCode;
        if (!keyPressedReg) begin
          if (matchNext == DEB_TARGET) begin
            keyPressedReg <= 1'b1;
            keyValueReg   <= hitCode;
            keyEventReg   <= 1'b1;
            matchCnt      <= 4'd0;
            releaseCnt    <= 4'd0;
          end else begin
            matchCnt <= matchNext;
          end
        end else begin
          if (releaseNext == DEB_TARGET) begin
            keyPressedReg <= 1'b0;
            releaseCnt    <= 4'd0;
            matchCnt      <= 4'd0;
          end else begin
            releaseCnt <= releaseNext;
          end
        end
      end
    end
  end

  assign keys.col_n      = colReg;
  assign keys.keyValue   = keyValueReg;
  assign keys.keyPressed = keyPressedReg;
  assign keys.keyEvent   = keyEventReg;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural key matrix and an event scoreboard.
// Expected key codes are queued when a press is staged and consumed on each keyEvent.
module tb_keypad_scanner;

  localparam int SWEEP = 17;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] held = 16'd0;
  logic [3:0]  rowDrive;
  logic        prevPressed = 1'b0;
  logic [3:0]  expQ[$];
  int          totalCnt = 0;
  int          passCnt  = 0;

  keypad_if kif ();

  keypad_scanner #(
    .SCAN_DIV      (4),
    .DEBOUNCE_SCANS(3)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .keys (kif.master)
  );

  always #5 clk = ~clk;

  // Held key at (r,c) pulls row r low while column c is driven low.
  always_comb begin
    rowDrive = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (held[r*4+c] && !kif.col_n[c]) rowDrive[r] = 1'b0;
      end
    end
  end
  assign kif.row_n = rowDrive;

  function automatic logic [15:0] keyMask(input logic [3:0] code);
    logic [15:0] m;
    int idx;
    m = 16'd0;
    case (code)
      4'h1: idx = 0;   4'h2: idx = 1;   4'h3: idx = 2;   4'hA: idx = 3;
      4'h4: idx = 4;   4'h5: idx = 5;   4'h6: idx = 6;   4'hB: idx = 7;
      4'h7: idx = 8;   4'h8: idx = 9;   4'h9: idx = 10;  4'hC: idx = 11;
      4'h0: idx = 12;  4'hF: idx = 13;  4'hE: idx = 14;  default: idx = 15;
    endcase
    m[idx] = 1'b1;
    return m;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    totalCnt++;
    assert (observed === expected) passCnt++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
  endtask

  task automatic applyStimulus(input logic [15:0] keys);
    held = keys;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sweeps(input int n);
    tick(SWEEP * n);
  endtask

  task automatic checkKey(input string tag, input logic pressed, input logic [3:0] value);
    checkOutput({tag, "Pressed"}, 32'(kif.keyPressed), 32'(pressed));
    checkOutput({tag, "Value"}, 32'(kif.keyValue), 32'(value));
  endtask

  // Scoreboard: every keyEvent must match a queued press and follow a released cycle.
  always @(negedge clk) begin
    if (kif.keyEvent === 1'b1) begin
      checkOutput("eventExpected", 32'(expQ.size() != 0), 32'd1);
      checkOutput("eventNotWhilePressed", 32'(prevPressed), 32'd0);
      if (expQ.size() != 0) checkOutput("eventKeyValue", 32'(kif.keyValue), 32'(expQ.pop_front()));
    end
    prevPressed = kif.keyPressed;
  end

  initial begin
    logic [3:0] expCol;

    rst_n = 1'b0;
    applyStimulus(keyMask(4'h2));
    tick(3);
    checkOutput("resetColN", 32'(kif.col_n), 32'hF);
    checkOutput("resetEvent", 32'(kif.keyEvent), 32'd0);
    checkKey("reset", 1'b0, 4'h0);

    @(negedge clk);
    rst_n = 1'b1;
    expQ.push_back(4'h2);
    tick(1);
    for (int c = 0; c < 4; c++) begin
      expCol = 4'b1111 ^ (4'b0001 << c);
      for (int k = 0; k < 4; k++) begin
        checkOutput("colScan", 32'(kif.col_n), 32'(expCol));
        tick(1);
      end
    end
    checkOutput("colEval", 32'(kif.col_n), 32'hF);
    tick(1);
    checkOutput("colWrap", 32'(kif.col_n), 32'hE);
    tick(33);
    checkKey("hold2Before", 1'b0, 4'h0);
    tick(1);
    checkKey("hold2Press", 1'b1, 4'h2);
    checkOutput("hold2Event", 32'(kif.keyEvent), 32'd1);
    tick(1);
    checkOutput("hold2EventOneCycle", 32'(kif.keyEvent), 32'd0);
    checkOutput("hold2Drained", 32'(expQ.size()), 32'd0);
    tick(SWEEP - 1);

    applyStimulus(16'd0);
    sweeps(2);
    checkKey("release2Partial", 1'b1, 4'h2);
    sweeps(1);
    checkKey("release2Done", 1'b0, 4'h2);

    applyStimulus(keyMask(4'h5));
    expQ.push_back(4'h5);
    sweeps(2);
    checkKey("press5Partial", 1'b0, 4'h2);
    sweeps(1);
    checkKey("press5", 1'b1, 4'h5);
    applyStimulus(16'd0);
    sweeps(2);
    checkKey("gap5", 1'b1, 4'h5);
    applyStimulus(keyMask(4'h5));
    sweeps(1);
    checkKey("repress5", 1'b1, 4'h5);
    applyStimulus(16'd0);
    sweeps(2);
    checkKey("gap5Again", 1'b1, 4'h5);
    sweeps(1);
    checkKey("release5", 1'b0, 4'h5);
    checkOutput("press5Drained", 32'(expQ.size()), 32'd0);

    for (int i = 0; i < 10; i++) begin
      applyStimulus((i % 2 == 0) ? keyMask(4'h8) : 16'd0);
      sweeps(1);
      checkKey("bounce8", 1'b0, 4'h5);
    end
    applyStimulus(16'd0);
    sweeps(1);

    applyStimulus(keyMask(4'h4) | keyMask(4'h6));
    expQ.push_back(4'h4);
    sweeps(3);
    checkKey("dual46", 1'b1, 4'h4);
    applyStimulus(keyMask(4'h4) | keyMask(4'h6) | keyMask(4'hD));
    sweeps(3);
    checkKey("addD", 1'b1, 4'h4);
    applyStimulus(keyMask(4'h4) | keyMask(4'h6));
    sweeps(2);
    checkKey("removeD", 1'b1, 4'h4);
    applyStimulus(16'd0);
    sweeps(3);
    checkKey("release4", 1'b0, 4'h4);
    checkOutput("dualDrained", 32'(expQ.size()), 32'd0);

    applyStimulus(keyMask(4'hA));
    sweeps(1);
    tick(8);
    rst_n = 1'b0;
    #1;
    checkOutput("midResetColN", 32'(kif.col_n), 32'hF);
    checkOutput("midResetEvent", 32'(kif.keyEvent), 32'd0);
    checkKey("midReset", 1'b0, 4'h0);
    tick(5);
    @(negedge clk);
    rst_n = 1'b1;
    expQ.push_back(4'hA);
    tick(1);
    checkOutput("postResetColN", 32'(kif.col_n), 32'hE);
    tick(SWEEP * 3 - 1);
    checkKey("holdABefore", 1'b0, 4'h0);
    tick(1);
    checkKey("holdAPress", 1'b1, 4'hA);
    tick(1);
    checkOutput("holdAEventOneCycle", 32'(kif.keyEvent), 32'd0);
    checkOutput("finalDrained", 32'(expQ.size()), 32'd0);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter SCAN_DIV, default 1000; clk cycles each column is driven (legal range 4..65535).
REQ-002 Parameter DEBOUNCE_SCANS, default 4; consecutive identical sweep results required to change state (legal range 1..15).
REQ-003 clk  input  1  system clock; all logic on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 col_n  output  4  column drive, active-low; at most one bit low at any time.
REQ-006 row_n  input  4  row sense, active-low, externally pulled up, asynchronous to clk.
REQ-007 keyValue  output  4  hex code of the debounced key; feeds keypad_decoder.keyValue.
REQ-008 keyPressed  output  1  high while a debounced key is held; feeds keypad_decoder.keyPressed.
REQ-009 keyEvent  output  1  one-cycle pulse on each debounced press.

Function
REQ-010 row_n SHALL pass through a two-flop synchronizer before any use.
REQ-011 The FSM SHALL have two states: SCAN and EVAL.
REQ-012 SCAN: column index c steps 0,1,2,3; col_n[c]=0 and all other bits=1 for exactly SCAN_DIV cycles per column.
REQ-013 The synchronized row vector SHALL be sampled only on the last cycle (div count = SCAN_DIV-1) of each column.
REQ-014 After column 3 is sampled, the FSM SHALL spend exactly one cycle in EVAL with col_n=4'b1111, then return to SCAN at column 0; sweep period = 4*SCAN_DIV+1 cycles.
REQ-015 Key code map (row r, column c): r0 = 1,2,3,A; r1 = 4,5,6,B; r2 = 7,8,9,C; r3 = 0,F,E,D.
REQ-016 Sweep result = hit/code of the first active key in scan order (column 0..3, then row 0..3 within a column); additional simultaneous keys are ignored.
REQ-017 Press debounce (keyPressed=0): a hit whose code equals that of the previous sweep increments the match count; a hit with a new code reloads the count to 1; an empty sweep clears it to 0.
REQ-018 When the match count reaches DEBOUNCE_SCANS in EVAL, on the next cycle keyPressed=1, keyValue=code, keyEvent=1 for exactly one cycle.
REQ-019 Release debounce (keyPressed=1): each empty sweep increments the release count; any hit, including a different key, clears it to 0; keyValue never changes while pressed (no rollover).
REQ-020 When the release count reaches DEBOUNCE_SCANS, on the next cycle keyPressed=0; keyValue retains its last code; no keyEvent.
REQ-021 Counters SHALL saturate at DEBOUNCE_SCANS; div counter width 16 bits; debounce counters 4 bits.
REQ-022 keyEvent SHALL never assert while keyPressed was already 1 in the previous cycle.

Reset
REQ-023 On rst_n=0, asynchronously: state=SCAN, column=0, div count=0, both debounce counters=0, synchronizer flops=4'b1111, col_n=4'b1111, keyValue=0, keyPressed=0, keyEvent=0.
REQ-024 After rst_n deasserts, column 0 SHALL be driven low on the first clk edge; a key held through reset SHALL require a full DEBOUNCE_SCANS sweeps before reporting.
REQ-025 Reset asserted mid-sweep or mid-debounce SHALL discard all partial results; no keyEvent is produced by reset.

Structure
REQ-026 Shared package keypad_pkg SHALL hold the state enum, the 4x4 key code table, and default SCAN_DIV/DEBOUNCE_SCANS constants.
REQ-027 One sub-module, sync_2ff (4 bits wide, reset value 1), SHALL implement the row synchronizer; all other logic resides in keypad_scanner.

Verification (SCAN_DIV=4, DEBOUNCE_SCANS=3, sweep=17 cycles)
REQ-028 Hold row0/col1 ("2") from reset -> col_n sequence 1110,1101,1011,0111 (4 cycles each) then 1111 for 1 cycle; keyPressed=1, keyValue=2, one keyEvent pulse, the cycle after the 3rd EVAL.
REQ-029 Press "5", release for 2 sweeps, press again -> keyPressed stays 1 throughout, single keyEvent; a full release of 3 sweeps -> keyPressed=0, keyValue stays 5.
REQ-030 Bounce: "8" present on alternate sweeps for 10 sweeps -> keyPressed stays 0, no keyEvent.
REQ-031 Hold "4" and "6" simultaneously -> keyValue=4 (column 0 first); while 4 is held, adding then removing "D" -> keyValue stays 4, no extra keyEvent.
REQ-032 Assert rst_n=0 during the 2nd matching sweep of "A", release rst_n with "A" still held -> outputs zero during reset; keyPressed rises only after 3 full post-reset sweeps with keyValue=A.
